soc_sysid_regs: RTL



---
 rtl/soc_sysid_pkg.sv | 24 ++
 rtl/soc_uptime_counter.sv | 37 +++
 rtl/soc_sysid_regs.sv | 112 +++++++++++
 3 files changed

// File: rtl/soc_sysid_pkg.sv
// Shared definitions for the system-ID register slave: register map,
// CTRL bit positions and default identity words.
package soc_sysid_pkg;

    typedef enum logic [2:0] {
        ADDR_ID        = 3'd0,
        ADDR_TIMESTAMP = 3'd1,
        ADDR_CAPS      = 3'd2,
        ADDR_UPTIME_LO = 3'd3,
        ADDR_UPTIME_HI = 3'd4,
        ADDR_SCRATCH   = 3'd5,
        ADDR_CTRL      = 3'd6,
        ADDR_RSVD      = 3'd7
    } sysid_addr_e;

    localparam int unsigned CTRL_CLEAR  = 0;
    localparam int unsigned CTRL_FREEZE = 1;
    localparam int unsigned CTRL_OVF    = 8;

    localparam logic [31:0] DEF_ID_VALUE  = 32'h0000_0000;
    localparam logic [31:0] DEF_TIMESTAMP = 32'd1673162897;
    localparam logic [31:0] DEF_CAPS      = 32'h0000_0001;

endpackage

// File: rtl/soc_uptime_counter.sv
// Free-running uptime counter with clear/freeze, wrap detection and a
// high-word snapshot taken whenever the low word is read.
module soc_uptime_counter #(
    parameter int unsigned CNT_W      = 64,
    parameter logic [63:0] CNT_PRESET = '0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        freeze,
    input  logic        snap,
    output logic [31:0] count_lo,
    output logic [31:0] hi_snap,
    output logic        wrap
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count   <= CNT_PRESET[CNT_W-1:0];
            hi_snap <= '0;
        end else begin
            if (snap)
                hi_snap <= 32'(count[CNT_W-1:32]);
            if (clear)
                count <= '0;
            else if (!freeze)
                count <= count + CNT_W'(1);
        end
    end

    // A clear in the wrap cycle suppresses the overflow indication.
    assign wrap     = !clear && !freeze && (&count);
    assign count_lo = count[31:0];

endmodule

// File: rtl/soc_sysid_regs.sv
// Avalon-MM system-ID slave: identity words, uptime counter, scratch and
// control/status register with a fixed one-cycle read latency.
module soc_sysid_regs
    import soc_sysid_pkg::*;
#(
    parameter logic [31:0] ID_VALUE    = DEF_ID_VALUE,
    parameter logic [31:0] TIMESTAMP   = DEF_TIMESTAMP,
    parameter logic [31:0] CAPS        = DEF_CAPS,
    parameter int unsigned CNT_W       = 64,
    parameter logic [31:0] SCRATCH_RST = 32'hDEAD_BEEF,
    parameter logic [63:0] CNT_PRESET  = '0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [2:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic [31:0] readdata,
    output logic        readdatavalid
);

    sysid_addr_e addr;
    logic        ctrl_wr;
    logic        clear;
    logic        snap;
    logic        wrap;
    logic        freeze;
    logic        ovf;
    logic [31:0] scratch;
    logic [31:0] count_lo;
    logic [31:0] hi_snap;
    logic [31:0] ctrl_rd;
    logic [31:0] rd_mux;

    assign addr    = sysid_addr_e'(address);
    assign ctrl_wr = write && (addr == ADDR_CTRL);
    assign clear   = ctrl_wr && byteenable[CTRL_CLEAR/8] && writedata[CTRL_CLEAR];
    assign snap    = read && (addr == ADDR_UPTIME_LO);

    soc_uptime_counter #(
        .CNT_W      (CNT_W),
        .CNT_PRESET (CNT_PRESET)
    ) u_uptime (
        .clock    (clock),
        .reset    (reset),
        .clear    (clear),
        .freeze   (freeze),
        .snap     (snap),
        .count_lo (count_lo),
        .hi_snap  (hi_snap),
        .wrap     (wrap)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            scratch <= SCRATCH_RST;
        end else if (write && (addr == ADDR_SCRATCH)) begin
            for (int unsigned b = 0; b < 4; b++)
                if (byteenable[b])
                    scratch[b*8 +: 8] <= writedata[b*8 +: 8];
        end
    end

    // Overflow set takes priority over a simultaneous write-1-to-clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            freeze <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            if (ctrl_wr && byteenable[CTRL_FREEZE/8])
                freeze <= writedata[CTRL_FREEZE];
            if (wrap)
                ovf <= 1'b1;
            else if (ctrl_wr && byteenable[CTRL_OVF/8] && writedata[CTRL_OVF])
                ovf <= 1'b0;
        end
    end

    always_comb begin
        ctrl_rd              = '0;
        ctrl_rd[CTRL_FREEZE] = freeze;
        ctrl_rd[CTRL_OVF]    = ovf;
    end

    always_comb begin
        rd_mux = '0;
        case (addr)
            ADDR_ID:        rd_mux = ID_VALUE;
            ADDR_TIMESTAMP: rd_mux = TIMESTAMP;
            ADDR_CAPS:      rd_mux = CAPS;
            ADDR_UPTIME_LO: rd_mux = count_lo;
            ADDR_UPTIME_HI: rd_mux = hi_snap;
            ADDR_SCRATCH:   rd_mux = scratch;
            ADDR_CTRL:      rd_mux = ctrl_rd;
            default:        rd_mux = '0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            readdata      <= '0;
            readdatavalid <= 1'b0;
        end else begin
            readdatavalid <= read;
            if (read)
                readdata <= rd_mux;
        end
    end

endmodule
